// File: rtl/ahb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bridge_arbiter
//
// Round-robin AHB-lite arbiter that lets NUM_MASTERS requesters share the
// single slave port of the AHB-to-APB bridge.
//
// Ownership is tracked twice:
//   owner_r    - address-phase owner (drives m_grant, Haddr/Hwrite/Htrans)
//   dp_owner_r - data-phase owner    (drives Hwdata, receives Hresp)
// Both move only on edges where the bridge reports Hreadyout=1, so a bridge
// wait state freezes the whole bus for every master.
//
// Arbitration on every ready edge:
//   1. keep the owner while it is mid-burst (SEQ) and either its hold budget
//      is not used up or nobody else is asking;
//   2. otherwise scan round-robin from the slot after rr_ptr_r, the owner
//      itself being the last candidate;
//   3. with no request at all, park on the current owner.
//
// Ports
//   Hclk, Hreset      clock, asynchronous active-high reset
//   m_req             per-master bus request
//   m_haddr/m_hwrite/m_htrans/m_hwdata   per-master AHB signals (packed)
//   m_grant           one-hot address-phase grant
//   m_hready          Hreadyout broadcast to every master
//   m_hresp           Hresp for the data-phase owner, 00 for the rest
//   m_hrdata          Hrdata broadcast
//   Haddr/Hwrite/Htrans/Hwdata/Hreadyin   to the bridge
//   Hreadyout/Hresp/Hrdata                from the bridge
// ---------------------------------------------------------------------------
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 4
) (
    input  logic                        Hclk,
    input  logic                        Hreset,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS*32-1:0]   m_haddr,
    input  logic [NUM_MASTERS-1:0]      m_hwrite,
    input  logic [NUM_MASTERS*2-1:0]    m_htrans,
    input  logic [NUM_MASTERS*32-1:0]   m_hwdata,
    output logic [NUM_MASTERS-1:0]      m_grant,
    output logic [NUM_MASTERS-1:0]      m_hready,
    output logic [NUM_MASTERS*2-1:0]    m_hresp,
    output logic [31:0]                 m_hrdata,
    output logic [31:0]                 Haddr,
    output logic                        Hwrite,
    output logic [1:0]                  Htrans,
    output logic [31:0]                 Hwdata,
    output logic                        Hreadyin,
    input  logic                        Hreadyout,
    input  logic [1:0]                  Hresp,
    input  logic [31:0]                 Hrdata
);

    // Index width is sized so the padded per-master tables have exactly
    // 2**IW entries; any owner value is then a legal table index.
    localparam int IW = (NUM_MASTERS > 2) ? 2 : 1;
    localparam int NP = 1 << IW;

    typedef logic [IW-1:0] idx_t;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [3:0] HOLD_SAT    = 4'hF;
    localparam logic [4:0] HOLD_LIMIT  = 5'(MAX_HOLD);

    // Per-master signals unpacked into padded tables (unused slots are 0).
    logic [31:0] haddr_a_s  [NP];
    logic [31:0] hwdata_a_s [NP];
    logic [1:0]  htrans_a_s [NP];
    logic        hwrite_a_s [NP];
    logic        req_a_s    [NP];

    // Arbitration state.
    idx_t        owner_r;
    idx_t        rr_ptr_r;
    logic [3:0]  hold_cnt_r;
    logic        dp_valid_r;
    idx_t        dp_owner_r;

    // Combinational arbitration results.
    logic        own_req_s;
    logic        others_s;
    logic        hold_ok_s;
    logic        keep_s;
    logic        found_s;
    logic        hit_s;
    idx_t        cand_s;
    idx_t        pick_s;
    idx_t        next_owner_s;
    logic        accept_s;
    logic        grant_chg_s;

    // Address-phase mux results before output.
    logic [31:0] haddr_s;
    logic        hwrite_s;
    logic [1:0]  htrans_s;
    logic [31:0] hwdata_s;

    genvar g;
    generate
        for (g = 0; g < NP; g++) begin : g_unpack
            if (g < NUM_MASTERS) begin : g_real
                assign haddr_a_s[g]  = m_haddr[g*32 +: 32];
                assign hwdata_a_s[g] = m_hwdata[g*32 +: 32];
                assign htrans_a_s[g] = m_htrans[g*2 +: 2];
                assign hwrite_a_s[g] = m_hwrite[g];
                assign req_a_s[g]    = m_req[g];
            end else begin : g_pad
                assign haddr_a_s[g]  = 32'h0000_0000;
                assign hwdata_a_s[g] = 32'h0000_0000;
                assign htrans_a_s[g] = HTRANS_IDLE;
                assign hwrite_a_s[g] = 1'b0;
                assign req_a_s[g]    = 1'b0;
            end
        end
    endgenerate

    // Next-owner selection: burst protection first, then round-robin scan.
    always_comb begin
        own_req_s = req_a_s[owner_r];
        others_s  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            others_s = others_s | (m_req[i] & (idx_t'(i) != owner_r));
        end

        // The transfer being accepted now would be hold_cnt_r+1.
        hold_ok_s = ({1'b0, hold_cnt_r} + 5'd1) < HOLD_LIMIT;
        keep_s    = own_req_s && (htrans_a_s[owner_r] == HTRANS_SEQ) &&
                    (hold_ok_s || !others_s);

        // Scan (rr_ptr+1) .. rr_ptr; the owner itself comes last. When
        // nobody requests, pick_s stays on the owner, which parks the bus.
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = owner_r;
        pick_s  = owner_r;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_s  = idx_t'((int'(rr_ptr_r) + k) % NUM_MASTERS);
            hit_s   = !found_s && req_a_s[cand_s];
            pick_s  = hit_s ? cand_s : pick_s;
            found_s = found_s | hit_s;
        end

        next_owner_s = keep_s ? owner_r : pick_s;
        accept_s     = Hreadyout && htrans_s[1];
        grant_chg_s  = Hreadyout && (next_owner_s != owner_r);
    end

    // Address-phase mux; reset forces the bus quiet in the same cycle.
    always_comb begin
        haddr_s  = 32'h0000_0000;
        hwrite_s = 1'b0;
        htrans_s = HTRANS_IDLE;
        if (Hreset) begin
            haddr_s  = 32'h0000_0000;
            hwrite_s = 1'b0;
            htrans_s = HTRANS_IDLE;
        end else begin
            haddr_s  = haddr_a_s[owner_r];
            hwrite_s = hwrite_a_s[owner_r];
            // A granted master that is not requesting must not start a transfer.
            htrans_s = own_req_s ? htrans_a_s[owner_r] : HTRANS_IDLE;
        end
    end

    // Data-phase write data from the data-phase owner, zero when no data phase.
    always_comb begin
        hwdata_s = 32'h0000_0000;
        if (Hreset || !dp_valid_r) begin
            hwdata_s = 32'h0000_0000;
        end else begin
            hwdata_s = hwdata_a_s[dp_owner_r];
        end
    end

    // Grant decode and response routing.
    always_comb begin
        m_grant = '0;
        m_hresp = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_grant[i]        = (owner_r == idx_t'(i));
            m_hresp[i*2 +: 2] = (dp_owner_r == idx_t'(i)) ? Hresp : 2'b00;
        end
    end

    assign Haddr    = haddr_s;
    assign Hwrite   = hwrite_s;
    assign Htrans   = htrans_s;
    assign Hwdata   = hwdata_s;
    assign Hreadyin = Hreadyout;
    assign m_hready = {NUM_MASTERS{Hreadyout}};
    assign m_hrdata = Hrdata;

    // Ownership, round-robin pointer, hold counter and data-phase tracking;
    // everything freezes while the bridge inserts wait states.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            hold_cnt_r <= 4'd0;
            dp_valid_r <= 1'b0;
            dp_owner_r <= '0;
        end else if (Hreadyout) begin
            owner_r    <= next_owner_s;
            dp_valid_r <= accept_s;
            dp_owner_r <= owner_r;
            if (grant_chg_s) begin
                rr_ptr_r   <= next_owner_s;
                hold_cnt_r <= 4'd0;
            end else if (accept_s && (hold_cnt_r != HOLD_SAT)) begin
                rr_ptr_r   <= rr_ptr_r;
                hold_cnt_r <= hold_cnt_r + 4'd1;
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                hold_cnt_r <= hold_cnt_r;
            end
        end else begin
            owner_r    <= owner_r;
            rr_ptr_r   <= rr_ptr_r;
            hold_cnt_r <= hold_cnt_r;
            dp_valid_r <= dp_valid_r;
            dp_owner_r <= dp_owner_r;
        end
    end

endmodule
